ip_ppi_responder: RTL

IP_PPI_RESPONDER -- requirements
Module: ip_ppi_responder

---
 rtl/ip_ppi_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ip_ppi_responder.sv
// PPI (8255-style) responder on the MSX-50BUS: slot register, keyboard column input,
// port C control bits and the mode/bit set-reset control port at I/O A8h..ABh.
module ip_ppi_responder (
    input  logic        n_reset,
    input  logic        clk,
    input  logic [15:0] bus_address,
    output logic        bus_io_cs,
    output logic        bus_memory_cs,
    input  logic [7:0]  bus_write_data,
    output logic [7:0]  bus_read_data,
    output logic        bus_read_ready,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic        bus_io,
    input  logic        bus_memory,
    output logic [7:0]  primary_slot,
    output logic [3:0]  key_matrix_row,
    output logic        motor_off,
    output logic        cas_write,
    output logic        caps_led_off,
    output logic        click_sound,
    input  logic [7:0]  key_matrix_column
);

    logic [7:0] primary_slot_r;
    logic [7:0] port_c_r;
    logic [7:0] control_word_r;
    logic [7:0] column_meta_r;
    logic [7:0] column_sync_r;
    logic       read_ready_r;
    logic [7:0] read_data_r;

    logic       access_s;
    logic       write_hit_s;
    logic       read_hit_s;
    logic [7:0] primary_slot_next_s;
    logic [7:0] port_c_next_s;
    logic [7:0] control_word_next_s;
    logic [7:0] read_data_next_s;

    // Upper address byte and the stored control word have no observable effect.
    logic unused_ok_s;
    assign unused_ok_s = &{1'b0, bus_address[15:8], control_word_r};

    assign bus_io_cs      = 1'b1;
    assign bus_memory_cs  = 1'b0;
    assign bus_read_ready = read_ready_r;
    assign bus_read_data  = read_data_r;
    assign primary_slot   = primary_slot_r;
    assign key_matrix_row = port_c_r[3:0];
    assign motor_off      = port_c_r[4];
    assign cas_write      = port_c_r[5];
    assign caps_led_off   = port_c_r[6];
    assign click_sound    = port_c_r[7];

    // Address decode, register write effects and read-response data selection.
    always_comb begin
        primary_slot_next_s = primary_slot_r;
        port_c_next_s       = port_c_r;
        control_word_next_s = control_word_r;
        read_data_next_s    = 8'h00;

        access_s    = bus_io && !bus_memory && (bus_address[7:2] == 6'b101010);
        write_hit_s = access_s && bus_write;
        // A simultaneous write wins; the read strobe is then dropped.
        read_hit_s  = access_s && bus_read && !bus_write;

        if (write_hit_s) begin
            case (bus_address[1:0])
                2'b00: primary_slot_next_s = bus_write_data;
                2'b01: primary_slot_next_s = primary_slot_r;
                2'b10: port_c_next_s = bus_write_data;
                2'b11: begin
                    if (bus_write_data[7]) begin
                        control_word_next_s = bus_write_data;
                        primary_slot_next_s = 8'h00;
                        port_c_next_s       = 8'h00;
                    end else begin
                        port_c_next_s[bus_write_data[3:1]] = bus_write_data[0];
                    end
                end
                default: primary_slot_next_s = primary_slot_r;
            endcase
        end else begin
            primary_slot_next_s = primary_slot_r;
        end

        if (read_hit_s) begin
            case (bus_address[1:0])
                2'b00:   read_data_next_s = primary_slot_r;
                2'b01:   read_data_next_s = column_sync_r;
                2'b10:   read_data_next_s = port_c_r;
                2'b11:   read_data_next_s = 8'hFF;
                default: read_data_next_s = 8'h00;
            endcase
        end else begin
            read_data_next_s = 8'h00;
        end
    end

    // Register state, column synchronizer and the one-cycle read response.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            primary_slot_r <= 8'h00;
            port_c_r       <= 8'h00;
            control_word_r <= 8'h82;
            column_meta_r  <= 8'h00;
            column_sync_r  <= 8'h00;
            read_ready_r   <= 1'b0;
            read_data_r    <= 8'h00;
        end else begin
            primary_slot_r <= primary_slot_next_s;
            port_c_r       <= port_c_next_s;
            control_word_r <= control_word_next_s;
            column_meta_r  <= key_matrix_column;
            column_sync_r  <= column_meta_r;
            read_ready_r   <= read_hit_s;
            read_data_r    <= read_data_next_s;
        end
    end

endmodule
